// File: rtl/aes_protocol_monitor.sv
// Passive AES core observer: judges (prev, current) state pairs, round numbering, output_valid timing, enables, busy timeout.
// Latency: a violation on the inputs sampled at edge N appears on err_pulse/err_flags after edge N+1. No backpressure; never drives the core.
module aes_protocol_monitor #(
    parameter int KEY_BITS = 128,
    parameter int CNT_W    = 8,
    parameter int MAX_LAT  = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       current_state,
    input  logic [3:0]       round_counter,
    input  logic             input_valid,
    input  logic             output_valid,
    input  logic             enable_key_expansion,
    input  logic             enable_sub_bytes,
    input  logic             enable_shift_rows,
    input  logic             enable_add_round_key,
    input  logic             err_clear,
    output logic [4:0]       err_flags,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       first_err_vec,
    output logic [2:0]       first_err_state,
    output logic [CNT_W-1:0] blocks_done
);
    localparam int NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : (KEY_BITS == 256) ? 14 : 0;
    localparam logic [3:0] NR_V = 4'(NR);
    localparam int BW = $clog2(MAX_LAT + 2);
    localparam logic [BW-1:0] BUSY_LIM = BW'(MAX_LAT + 1);

    generate
        if (NR == 0 || MAX_LAT < 5 * NR) begin : g_bad_param
            $error("aes_protocol_monitor: unsupported KEY_BITS or MAX_LAT too small");
        end
    endgenerate

    localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_KE = 3'd2, S_SB = 3'd3,
                           S_SR = 3'd4, S_MC = 3'd5, S_ARK = 3'd6;

    logic [2:0]    prev_state;
    logic [3:0]    prev_round;
    logic          prev_iv;
    logic [3:0]    exp_round;
    logic [BW-1:0] busy_cnt;

    logic [4:0]    viol_q;
    logic [2:0]    state_q;
    logic          clr_q;
    logic          done_q;

    logic          trans_ok;
    logic [3:0]    exp_now;
    logic          valid_req;
    logic          busy;
    logic [4:0]    viol;

    always_comb begin
        trans_ok = 1'b0;
        case (prev_state)
            S_IDLE:  trans_ok = prev_iv ? (current_state == S_INIT) : (current_state == S_IDLE);
            S_INIT:  trans_ok = (current_state == S_KE);
            S_KE:    trans_ok = (current_state == S_SB);
            S_SB:    trans_ok = (current_state == S_SR);
            S_SR:    trans_ok = (prev_round < NR_V && current_state == S_MC) ||
                                (prev_round == NR_V && current_state == S_ARK);
            S_MC:    trans_ok = (current_state == S_ARK);
            S_ARK:   trans_ok = (prev_round < NR_V && current_state == S_KE) ||
                                (prev_round == NR_V && current_state == S_IDLE);
            default: trans_ok = 1'b0;
        endcase

        // Round numbering restarts at INITIAL_ROUND and advances on each fresh KEY_EXPANSION.
        exp_now = exp_round;
        if (current_state == S_INIT)
            exp_now = 4'd0;
        else if (current_state == S_KE && prev_state != S_KE)
            exp_now = exp_round + 4'd1;

        valid_req = (prev_state == S_ARK) && (prev_round == NR_V) && (current_state == S_IDLE);
        busy      = (current_state != S_IDLE);

        viol    = 5'd0;
        viol[0] = !trans_ok;
        viol[1] = busy && (round_counter != exp_now);
        viol[2] = (output_valid != valid_req);
        viol[3] = (enable_key_expansion != (current_state == S_KE)) ||
                  (enable_sub_bytes     != (current_state == S_SB)) ||
                  (enable_shift_rows    != (current_state == S_SR)) ||
                  (enable_add_round_key != (current_state == S_INIT || current_state == S_ARK));
        viol[4] = busy && (busy_cnt == BUSY_LIM - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= S_IDLE;
            prev_round <= 4'd0;
            prev_iv    <= 1'b0;
            exp_round  <= 4'd0;
            busy_cnt   <= '0;
            viol_q     <= 5'd0;
            state_q    <= 3'd0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            prev_state <= current_state;
            prev_round <= round_counter;
            prev_iv    <= input_valid;
            // Resync to the observed round so one skip is reported only once.
            exp_round  <= busy ? round_counter : 4'd0;
            if (!busy)
                busy_cnt <= '0;
            else if (busy_cnt != BUSY_LIM)
                busy_cnt <= busy_cnt + 1'b1;
            viol_q     <= viol;
            state_q    <= current_state;
            clr_q      <= err_clear;
            done_q     <= valid_req && output_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags       <= 5'd0;
            err_pulse       <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= 5'd0;
            first_err_state <= 3'd0;
            blocks_done     <= '0;
        end else begin
            err_pulse   <= (viol_q != 5'd0);
            blocks_done <= blocks_done + CNT_W'(done_q);
            if (clr_q) begin
                // Clear first, then record whatever the same sample flagged.
                err_flags       <= viol_q;
                err_count       <= (viol_q != 5'd0) ? CNT_W'(1) : '0;
                first_err_vec   <= viol_q;
                first_err_state <= (viol_q != 5'd0) ? state_q : 3'd0;
            end else if (viol_q != 5'd0) begin
                err_flags <= err_flags | viol_q;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_err_vec   <= viol_q;
                    first_err_state <= state_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_protocol_monitor.sv
// Directed bench for aes_protocol_monitor: a 128-bit and a 256-bit instance share the same stimulus.
module tb_aes_protocol_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] current_state;
    logic [3:0] round_counter;
    logic       input_valid, output_valid;
    logic       enable_key_expansion, enable_sub_bytes, enable_shift_rows, enable_add_round_key;
    logic       err_clear;
    logic [3:0] en_flip;

    logic [4:0] flags_a, fev_a, flags_b, fev_b;
    logic       pulse_a, pulse_b;
    logic [7:0] cnt_a, done_a, cnt_b, done_b;
    logic [2:0] fes_a, fes_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_protocol_monitor #(.KEY_BITS(128), .CNT_W(8), .MAX_LAT(96)) dut (
        .clk(clk), .rst(rst), .current_state(current_state), .round_counter(round_counter),
        .input_valid(input_valid), .output_valid(output_valid),
        .enable_key_expansion(enable_key_expansion), .enable_sub_bytes(enable_sub_bytes),
        .enable_shift_rows(enable_shift_rows), .enable_add_round_key(enable_add_round_key),
        .err_clear(err_clear), .err_flags(flags_a), .err_pulse(pulse_a), .err_count(cnt_a),
        .first_err_vec(fev_a), .first_err_state(fes_a), .blocks_done(done_a));

    aes_protocol_monitor #(.KEY_BITS(256), .CNT_W(8), .MAX_LAT(96)) dut256 (
        .clk(clk), .rst(rst), .current_state(current_state), .round_counter(round_counter),
        .input_valid(input_valid), .output_valid(output_valid),
        .enable_key_expansion(enable_key_expansion), .enable_sub_bytes(enable_sub_bytes),
        .enable_shift_rows(enable_shift_rows), .enable_add_round_key(enable_add_round_key),
        .err_clear(err_clear), .err_flags(flags_b), .err_pulse(pulse_b), .err_count(cnt_b),
        .first_err_vec(fev_b), .first_err_state(fes_b), .blocks_done(done_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample with correct enables (optionally corrupted by en_flip) and advance one clock.
    task automatic cyc(input logic [2:0] st, input int rnd, input logic iv, input logic ov);
        current_state        = st;
        round_counter        = 4'(rnd);
        input_valid          = iv;
        output_valid         = ov;
        enable_key_expansion = (st == 3'd2) ^ en_flip[3];
        enable_sub_bytes     = (st == 3'd3) ^ en_flip[2];
        enable_shift_rows    = (st == 3'd4) ^ en_flip[1];
        enable_add_round_key = (st == 3'd1 || st == 3'd6) ^ en_flip[0];
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int nr, input int skip, input logic mc_last);
        int r;
        cyc(3'd0, 0, 1'b1, 1'b0);
        cyc(3'd1, 0, 1'b0, 1'b0);
        r = 1;
        while (r <= nr) begin
            if (r == skip) r++;
            cyc(3'd2, r, 1'b0, 1'b0);
            cyc(3'd3, r, 1'b0, 1'b0);
            cyc(3'd4, r, 1'b0, 1'b0);
            if (r < nr || mc_last) cyc(3'd5, r, 1'b0, 1'b0);
            cyc(3'd6, r, 1'b0, 1'b0);
            r++;
        end
        cyc(3'd0, 0, 1'b0, 1'b1);
        cyc(3'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, flags_a, 0);
        chk({tag, "_pulse"}, pulse_a, 0);
        chk({tag, "_count"}, cnt_a, 0);
        chk({tag, "_fev"},   fev_a, 0);
        chk({tag, "_fes"},   fes_a, 0);
        chk({tag, "_done"},  done_a, 0);
    endtask

    initial begin
        int hits;
        int at;
        en_flip   = 4'b0000;
        err_clear = 1'b0;
        rst       = 1'b1;
        cyc(3'd0, 0, 1'b0, 1'b0);
        cyc(3'd0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_all_zero("reset");
        cyc(3'd0, 0, 1'b0, 1'b0);

        // One legal AES-128 block: 50 busy cycles.
        run_block(10, 0, 1'b0);
        chk("legal_flags", flags_a, 5'b00000);
        chk("legal_count", cnt_a, 0);
        chk("legal_done",  done_a, 1);

        // Round 4 skipped: a single ROUND_ERR at the KEY_EXPANSION entry showing round 5.
        run_block(10, 4, 1'b0);
        chk("skip_flags", flags_a, 5'b00010);
        chk("skip_count", cnt_a, 1);
        chk("skip_fev",   fev_a, 5'b00010);
        chk("skip_fes",   fes_a, 3'd2);
        chk("skip_done",  done_a, 2);

        // Stray sub_bytes enable in SHIFT_ROWS together with err_clear.
        cyc(3'd0, 0, 1'b1, 1'b0);
        cyc(3'd1, 0, 1'b0, 1'b0);
        cyc(3'd2, 1, 1'b0, 1'b0);
        cyc(3'd3, 1, 1'b0, 1'b0);
        en_flip   = 4'b0100;
        err_clear = 1'b1;
        cyc(3'd4, 1, 1'b0, 1'b0);
        en_flip   = 4'b0000;
        err_clear = 1'b0;
        cyc(3'd5, 1, 1'b0, 1'b0);
        chk("clr_flags", flags_a, 5'b01000);
        chk("clr_count", cnt_a, 1);
        chk("clr_fev",   fev_a, 5'b01000);
        chk("clr_fes",   fes_a, 3'd4);
        chk("clr_pulse", pulse_a, 1);
        cyc(3'd6, 1, 1'b0, 1'b0);
        chk("clr_pulse_end", pulse_a, 0);

        // Reset mid-block clears everything including blocks_done.
        rst = 1'b1;
        cyc(3'd2, 2, 1'b0, 1'b0);
        rst = 1'b0;
        chk_all_zero("rst_mid");
        // First post-reset sample is judged against prev=IDLE (and expected round 1).
        cyc(3'd2, 2, 1'b0, 1'b0);
        cyc(3'd0, 0, 1'b0, 1'b0);
        chk("post_rst_fev", fev_a, 5'b00011);
        chk("post_rst_fes", fes_a, 3'd2);

        // AES-256 instance: ten full rounds, then ADD_ROUND_KEY at round 10 drops to IDLE.
        rst = 1'b1;
        cyc(3'd0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(3'd0, 0, 1'b0, 1'b0);
        run_block(10, 0, 1'b1);
        chk("k256_flags", flags_b, 5'b00101);
        chk("k256_count", cnt_b, 1);
        chk("k256_fev",   fev_b, 5'b00101);
        chk("k256_fes",   fes_b, 3'd0);
        chk("k256_done",  done_b, 0);

        // Stuck in SUB_BYTES; err_clear held so err_flags shows each sample's vector.
        rst = 1'b1;
        cyc(3'd0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(3'd0, 0, 1'b0, 1'b0);
        cyc(3'd0, 0, 1'b1, 1'b0);
        cyc(3'd1, 0, 1'b0, 1'b0);
        cyc(3'd2, 1, 1'b0, 1'b0);
        err_clear = 1'b1;
        hits = 0;
        at   = 0;
        for (int k = 3; k <= 110; k++) begin
            cyc(3'd3, 1, 1'b0, 1'b0);
            if (flags_a[4]) begin
                hits++;
                at = k - 1;
            end
        end
        chk("tmo_hits",  hits, 1);
        chk("tmo_cycle", at, 97);
        chk("tmo_count", cnt_a, 1);
        chk("tmo_flags", flags_a, 5'b00001);
        err_clear = 1'b0;
        for (int k = 0; k < 260; k++) cyc(3'd3, 1, 1'b0, 1'b0);
        chk("sat_count", cnt_a, 255);
        chk("sat_pulse", pulse_a, 1);
        chk("sat_fev",   fev_a, 5'b00001);

        rst = 1'b1;
        cyc(3'd3, 1, 1'b0, 1'b0);
        rst = 1'b0;
        chk_all_zero("rst_stuck");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
